mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the core's instruction-fetch
//  port and its load/store port, so the RV32I core can run from a unified memory.
//  Valid/ready request handshake per requester, one outstanding transaction,
//  fixed memory latency, data-over-fetch priority with a starvation guard.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width; byte enables are DATA_W/8 wide
//  MEM_LAT     1   cycles from mem_en to valid mem_rdata (>=1)
//  STARVE_MAX  4   consecutive data grants, with fetch waiting, before fetch is forced
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous reset, active-low
//  i_req_valid  in   1         fetch request valid
//  i_req_ready  out  1         fetch request accepted this cycle
//  i_req_addr   in   ADDR_W    fetch address
//  i_rsp_valid  out  1         fetch data valid, one-cycle pulse
//  i_rsp_data   out  DATA_W    fetched word
//  d_req_valid  in   1         load/store request valid
//  d_req_ready  out  1         load/store request accepted this cycle
//  d_req_addr   in   ADDR_W    load/store address
//  d_req_we     in   1         1 = store, 0 = load
//  d_req_be     in   DATA_W/8  byte enables
//  d_req_wdata  in   DATA_W    store data
//  d_rsp_valid  out  1         load data / store ack, one-cycle pulse
//  d_rsp_data   out  DATA_W    load data; 0 on store ack
//  mem_en       out  1         memory access strobe
//  mem_we       out  1         memory write enable
//  mem_addr     out  ADDR_W    memory address
//  mem_be       out  DATA_W/8  memory byte enables
//  mem_wdata    out  DATA_W    memory write data
//  mem_rdata    in   DATA_W    memory read data
// BEHAVIOUR
//  - FSM: IDLE -> WAIT (latency counter) -> RESP -> IDLE.
//  - IDLE: at most one of i_req_ready/d_req_ready high, combinationally from valids.
//    Winner is data, unless starve_cnt == STARVE_MAX and i_req_valid, then fetch.
//  - Accept = valid & ready at cycle T. In T: mem_en=1, mem_* driven from winner
//    (fetch: we=0, be=all ones, wdata=0). Owner and we latched; to WAIT.
//  - MEM_LAT==1 skips WAIT: T+1 is RESP. Otherwise WAIT counts down to RESP at T+MEM_LAT.
//  - RESP: owner's rsp_valid=1 for exactly one cycle; rsp_data=mem_rdata (load/fetch)
//    or 0 (store). Non-owner rsp_valid stays 0. Next state IDLE.
//  - Both ready outputs 0 in WAIT and RESP; next accept earliest T+MEM_LAT+1.
//  - Outside accept cycles mem_en=0, mem_we=0, mem_addr/be/wdata=0.
//  - starve_cnt (width clog2(STARVE_MAX+1)): on data grant with i_req_valid=1,
//    +1 (saturates); on fetch grant, or data grant with i_req_valid=0, -> 0.
//  - Requesters hold req fields stable while valid & !ready; arbiter relies on it.
//  - d_req_be passed unmodified; no alignment checks here.
//  - rst low (any time, incl. WAIT/RESP): state IDLE, starve_cnt 0, all outputs 0,
//    in-flight transaction dropped, no response ever issued for it.
//  - First accept possible in the first cycle after rst deasserts.
// TESTING
//  - Fetch only, MEM_LAT=1, mem word0=0x3E800093: i_req addr 0 -> mem_en cycle T,
//    addr 0, be 4'hF; i_rsp_valid in T+1, data 0x3E800093; d_rsp_valid stays 0.
//  - Both valid in same cycle: d_req_ready=1, i_req_ready=0; fetch accepted at T+2.
//  - Store then load: sw addr 8 be 4'hF wdata 0x3FE -> d_rsp_valid, data 0;
//    lw addr 8 -> d_rsp_data 0x3FE; sb addr 12 be 4'b0001 wdata 0xFF -> mem_be 4'b0001.
//  - Starvation, both valid continuously, STARVE_MAX=4: grant order D,D,D,D,I,D,D,D,D,I.
//  - MEM_LAT=3: accept at T -> rsp_valid only at T+3, readies 0 T+1..T+3, accept at T+4.
//  - rst low during WAIT: no rsp_valid, all outputs 0; after release fetch addr 4
//    served normally with correct data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and memory bus bundle for mem_arbiter.
// The arbiter uses the slave view. The requesters and the memory use the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_we;
  logic [BE_W-1:0]   d_req_be;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    input  mem_rdata,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_be, d_req_wdata,
    output mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the fetch port and the load/store port share one
// single-port synchronous memory. Only one transaction is outstanding at a time.
// Data requests win over fetch requests. A starvation counter forces a fetch grant
// after STARVE_MAX data grants in a row while a fetch was waiting.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  // WAIT covers MEM_LAT-1 cycles, so the counter starts at MEM_LAT-2 and counts down to zero.
  localparam logic [LAT_W-1:0] WAIT_LOAD  = LAT_W'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [SC_W-1:0]   starve_cnt;
  logic              owner_fetch;
  logic              owner_we;
  logic              i_rsp_valid_r;
  logic              d_rsp_valid_r;

  logic              i_ready;
  logic              d_ready;
  logic              i_accept;
  logic              d_accept;

  // Pick the winner while idle. Both ready outputs are forced low during reset.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    if (rst && (state == ST_IDLE)) begin
      if (bus.i_req_valid && (!bus.d_req_valid || (starve_cnt == STARVE_LIM))) begin
        i_ready = 1'b1;
      end else if (bus.d_req_valid) begin
        d_ready = 1'b1;
      end else begin
        i_ready = 1'b0;
        d_ready = 1'b0;
      end
    end else begin
      i_ready = 1'b0;
      d_ready = 1'b0;
    end
  end

  assign i_accept = i_ready & bus.i_req_valid;
  assign d_accept = d_ready & bus.d_req_valid;

  // Drive the memory strobe and its fields only in the accept cycle. They are zero otherwise.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_be    = {BE_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (i_accept) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.i_req_addr;
      bus.mem_be    = {BE_W{1'b1}};
    end else if (d_accept) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_req_we;
      bus.mem_addr  = bus.d_req_addr;
      bus.mem_be    = bus.d_req_be;
      bus.mem_wdata = bus.d_req_wdata;
    end else begin
      bus.mem_en    = 1'b0;
    end
  end

  // Transaction FSM (IDLE -> WAIT -> RESP), starvation counter and registered response strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      lat_cnt       <= {LAT_W{1'b0}};
      starve_cnt    <= {SC_W{1'b0}};
      owner_fetch   <= 1'b0;
      owner_we      <= 1'b0;
      i_rsp_valid_r <= 1'b0;
      d_rsp_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_accept || d_accept) begin
            owner_fetch <= i_accept;
            owner_we    <= d_accept & bus.d_req_we;
            if (d_accept && bus.i_req_valid) begin
              if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + SC_W'(1);
              end else begin
                starve_cnt <= starve_cnt;
              end
            end else begin
              starve_cnt <= {SC_W{1'b0}};
            end
            if (MEM_LAT == 1) begin
              state         <= ST_RESP;
              i_rsp_valid_r <= i_accept;
              d_rsp_valid_r <= d_accept;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= WAIT_LOAD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == {LAT_W{1'b0}}) begin
            state         <= ST_RESP;
            i_rsp_valid_r <= owner_fetch;
            d_rsp_valid_r <= ~owner_fetch;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          i_rsp_valid_r <= 1'b0;
          d_rsp_valid_r <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          i_rsp_valid_r <= 1'b0;
          d_rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_req_ready = i_ready;
  assign bus.d_req_ready = d_ready;
  assign bus.i_rsp_valid = i_rsp_valid_r;
  assign bus.d_rsp_valid = d_rsp_valid_r;
  // The response strobe is aligned with mem_rdata, so the read data passes straight through.
  assign bus.i_rsp_data  = i_rsp_valid_r ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rsp_data  = (d_rsp_valid_r && !owner_we) ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Instance u0 uses MEM_LAT=1 and instance u1 uses MEM_LAT=3.
// Each instance has its own memory stub.
// A timestamp-based transaction model predicts every output on every cycle.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic        iv [2];
  logic [31:0] ia [2];
  logic        dv [2];
  logic        dwe [2];
  logic [31:0] da [2];
  logic [3:0]  dbe [2];
  logic [31:0] dwd [2];

  logic        o_iready [2];
  logic        o_dready [2];
  logic        o_irv [2];
  logic        o_drv [2];
  logic [31:0] o_ird [2];
  logic [31:0] o_drd [2];
  logic        o_men [2];
  logic        o_mwe [2];
  logic [31:0] o_maddr [2];
  logic [3:0]  o_mbe [2];
  logic [31:0] o_mwd [2];

  int errors = 0;
  int checks = 0;
  int cyc;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h3E800093;
    if (i == 1) return 32'h00100113;
    return 32'hA5000000 | 32'(i);
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [31:0] mem [NW];
    logic [31:0] pipe [L];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign bus.i_req_valid = iv[k];
    assign bus.i_req_addr  = ia[k];
    assign bus.d_req_valid = dv[k];
    assign bus.d_req_we    = dwe[k];
    assign bus.d_req_addr  = da[k];
    assign bus.d_req_be    = dbe[k];
    assign bus.d_req_wdata = dwd[k];
    assign bus.mem_rdata   = pipe[L-1];

    assign o_iready[k] = bus.i_req_ready;
    assign o_dready[k] = bus.d_req_ready;
    assign o_irv[k]    = bus.i_rsp_valid;
    assign o_drv[k]    = bus.d_rsp_valid;
    assign o_ird[k]    = bus.i_rsp_data;
    assign o_drd[k]    = bus.d_rsp_data;
    assign o_men[k]    = bus.mem_en;
    assign o_mwe[k]    = bus.mem_we;
    assign o_maddr[k]  = bus.mem_addr;
    assign o_mbe[k]    = bus.mem_be;
    assign o_mwd[k]    = bus.mem_wdata;

    // Synchronous memory stub: the read data comes out L cycles after the strobe. Contents reload while reset is low.
    always @(posedge clk) begin
      if (!rst) begin
        for (int w = 0; w < NW; w++) mem[w] <= init_word(w);
        for (int s = 0; s < L; s++) pipe[s] <= 32'd0;
      end else begin
        pipe[0] <= bus.mem_en ? mem[bus.mem_addr[5:2]] : 32'd0;
        for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
        if (bus.mem_en && bus.mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%s expected=%s", nm, act, exp);
    end
  endtask

  // Model state: the accept time fixes the response time and the next free time.
  int          next_free [2];
  int          rsp_at [2];
  int          starve [2];
  logic        rsp_pend [2];
  logic        rsp_fetch [2];
  logic [31:0] rsp_data [2];
  logic [31:0] ref_mem [2][NW];
  string       mlog, dlog;
  int          acc1 [$];
  int          rsp1 [$];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : model
    int lt;
    logic e_ir, e_dr, e_irv, e_drv, e_men, e_mwe, rsp_now;
    logic [31:0] e_ird, e_drd, e_maddr, e_mwd;
    logic [3:0] e_mbe;
    for (int k = 0; k < 2; k++) begin
      next_free[k] = 0; rsp_at[k] = 0; starve[k] = 0;
      rsp_pend[k] = 1'b0; rsp_fetch[k] = 1'b0; rsp_data[k] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        lt = (k == 0) ? 1 : 3;
        e_ir = 1'b0; e_dr = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_men = 1'b0; e_mwe = 1'b0;
        e_ird = 32'd0; e_drd = 32'd0; e_maddr = 32'd0; e_mwd = 32'd0; e_mbe = 4'd0;
        rsp_now = 1'b0;
        if (!rst) begin
          next_free[k] = 0; rsp_pend[k] = 1'b0; starve[k] = 0;
          for (int w = 0; w < NW; w++) ref_mem[k][w] = init_word(w);
        end else begin
          rsp_now = rsp_pend[k] && (rsp_at[k] == cyc);
          if (rsp_now) begin
            e_irv = rsp_fetch[k];
            e_drv = !rsp_fetch[k];
            if (rsp_fetch[k]) e_ird = rsp_data[k];
            else e_drd = rsp_data[k];
          end
          if (cyc >= next_free[k]) begin
            if (iv[k] && (!dv[k] || starve[k] == SMAX)) e_ir = 1'b1;
            else if (dv[k]) e_dr = 1'b1;
          end
          if (e_ir) begin
            e_men = 1'b1; e_maddr = ia[k]; e_mbe = 4'hF;
          end else if (e_dr) begin
            e_men = 1'b1; e_mwe = dwe[k]; e_maddr = da[k]; e_mbe = dbe[k]; e_mwd = dwd[k];
          end
        end
        chk($sformatf("u%0d.i_req_ready@%0d", k, cyc), 32'(o_iready[k]), 32'(e_ir));
        chk($sformatf("u%0d.d_req_ready@%0d", k, cyc), 32'(o_dready[k]), 32'(e_dr));
        chk($sformatf("u%0d.i_rsp_valid@%0d", k, cyc), 32'(o_irv[k]), 32'(e_irv));
        chk($sformatf("u%0d.d_rsp_valid@%0d", k, cyc), 32'(o_drv[k]), 32'(e_drv));
        chk($sformatf("u%0d.mem_en@%0d", k, cyc), 32'(o_men[k]), 32'(e_men));
        chk($sformatf("u%0d.mem_we@%0d", k, cyc), 32'(o_mwe[k]), 32'(e_mwe));
        chk($sformatf("u%0d.mem_addr@%0d", k, cyc), o_maddr[k], e_maddr);
        chk($sformatf("u%0d.mem_be@%0d", k, cyc), 32'(o_mbe[k]), 32'(e_mbe));
        chk($sformatf("u%0d.mem_wdata@%0d", k, cyc), o_mwd[k], e_mwd);
        if (e_irv) chk($sformatf("u%0d.i_rsp_data@%0d", k, cyc), o_ird[k], e_ird);
        if (e_drv) chk($sformatf("u%0d.d_rsp_data@%0d", k, cyc), o_drd[k], e_drd);
        if (rst) begin
          if (rsp_now) rsp_pend[k] = 1'b0;
          if (e_ir || e_dr) begin
            rsp_pend[k]  = 1'b1;
            rsp_at[k]    = cyc + lt;
            next_free[k] = cyc + lt + 1;
            rsp_fetch[k] = e_ir;
            if (e_ir) begin
              rsp_data[k] = ref_mem[k][ia[k][5:2]];
              starve[k] = 0;
            end else begin
              if (dwe[k]) begin
                for (int b = 0; b < 4; b++)
                  if (dbe[k][b]) ref_mem[k][da[k][5:2]][8*b +: 8] = dwd[k][8*b +: 8];
                rsp_data[k] = 32'd0;
              end else begin
                rsp_data[k] = ref_mem[k][da[k][5:2]];
              end
              starve[k] = iv[k] ? ((starve[k] < SMAX) ? starve[k] + 1 : SMAX) : 0;
            end
          end
        end
        if (k == 0) begin
          if (e_ir) mlog = {mlog, "I"};
          if (e_dr) mlog = {mlog, "D"};
          if (o_iready[0]) dlog = {dlog, "I"};
          if (o_dready[0]) dlog = {dlog, "D"};
        end else begin
          if (o_iready[1] || o_dready[1]) acc1.push_back(cyc);
          if (o_irv[1] || o_drv[1]) rsp1.push_back(cyc);
        end
      end
    end
  end

  // One handshake: raise valid, wait for ready, drop the request, wait for the response strobe.
  task automatic req(input int k, input logic is_d, input logic we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic [3:0] acc_be);
    logic got;
    rdata = 32'd0;
    acc_be = 4'd0;
    @(posedge clk); #1;
    if (is_d) begin
      dv[k] = 1'b1; dwe[k] = we; da[k] = a; dbe[k] = be; dwd[k] = wd;
    end else begin
      iv[k] = 1'b1; ia[k] = a;
    end
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (is_d ? o_dready[k] : o_iready[k]) begin
        got = 1'b1;
        acc_be = o_mbe[k];
      end
    end
    chk($sformatf("u%0d.accept_seen", k), 32'(got), 32'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0; ia[k] = 32'd0; dv[k] = 1'b0; dwe[k] = 1'b0; da[k] = 32'd0; dbe[k] = 4'd0; dwd[k] = 32'd0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (n > 0 || k == 0) @(negedge clk);
      if (k == 1 && n == 0) @(negedge clk);
      if (is_d ? o_drv[k] : o_irv[k]) begin
        got = 1'b1;
        rdata = is_d ? o_drd[k] : o_ird[k];
      end
    end
    chk($sformatf("u%0d.response_seen", k), 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    logic [3:0] be;
    logic got;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ia[k] = 32'd0; dv[k] = 1'b0; dwe[k] = 1'b0;
      da[k] = 32'd0; dbe[k] = 4'd0; dwd[k] = 32'd0;
    end
    mlog = ""; dlog = "";
    // Requests asserted during reset must not be granted.
    @(posedge clk); #1;
    iv[0] = 1'b1; dv[0] = 1'b1; dbe[0] = 4'hF;
    @(negedge clk);
    chk("rst_i_ready", 32'(o_iready[0]), 32'd0);
    chk("rst_d_ready", 32'(o_dready[0]), 32'd0);
    chk("rst_mem_en", 32'(o_men[0]), 32'd0);
    @(posedge clk); #1;
    iv[0] = 1'b0; dv[0] = 1'b0; dbe[0] = 4'd0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Fetch only, word 0.
    req(0, 1'b0, 1'b0, 32'd0, 4'hF, 32'd0, rd, be);
    chk("fetch0_data", rd, 32'h3E800093);
    chk("fetch0_mem_be", 32'(be), 32'hF);

    // Both valid in the same cycle: data first, then fetch two cycles later.
    @(posedge clk); #1;
    iv[0] = 1'b1; ia[0] = 32'd4; dv[0] = 1'b1; dwe[0] = 1'b0; da[0] = 32'd0; dbe[0] = 4'hF;
    @(negedge clk);
    chk("both_d_ready", 32'(o_dready[0]), 32'd1);
    chk("both_i_ready", 32'(o_iready[0]), 32'd0);
    @(posedge clk); #1;
    dv[0] = 1'b0; dbe[0] = 4'd0;
    @(negedge clk);
    chk("both_i_ready_t1", 32'(o_iready[0]), 32'd0);
    chk("both_d_rsp_data", o_drd[0], 32'h3E800093);
    @(posedge clk); #1;
    @(negedge clk);
    chk("both_i_ready_t2", 32'(o_iready[0]), 32'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0; ia[0] = 32'd0;
    @(negedge clk);
    chk("both_i_rsp_data", o_ird[0], 32'h00100113);

    // Store, load back, byte store, load back.
    req(0, 1'b1, 1'b1, 32'd8, 4'hF, 32'h3FE, rd, be);
    chk("sw_ack_data", rd, 32'd0);
    req(0, 1'b1, 1'b0, 32'd8, 4'hF, 32'd0, rd, be);
    chk("lw8_data", rd, 32'h000003FE);
    req(0, 1'b1, 1'b1, 32'd12, 4'b0001, 32'hFF, rd, be);
    chk("sb_mem_be", 32'(be), 32'h1);
    req(0, 1'b1, 1'b0, 32'd12, 4'hF, 32'd0, rd, be);
    chk("lw12_data", rd, 32'hA50000FF);

    // Starvation: both requesters valid for 20 cycles, which gives 10 grants.
    @(posedge clk); #1;
    mlog = ""; dlog = "";
    iv[0] = 1'b1; ia[0] = 32'd0; dv[0] = 1'b1; dwe[0] = 1'b0; da[0] = 32'd16; dbe[0] = 4'hF;
    repeat (20) @(posedge clk);
    #1;
    iv[0] = 1'b0; dv[0] = 1'b0; dbe[0] = 4'd0; da[0] = 32'd0;
    chk_str("starve_order_dut", dlog, "DDDDIDDDDI");
    chk_str("starve_order_model", mlog, "DDDDIDDDDI");
    repeat (3) @(posedge clk);

    // MEM_LAT=3: fetch held valid. Accepts are 4 cycles apart and each response comes 3 cycles after its accept.
    #1;
    acc1.delete(); rsp1.delete();
    iv[1] = 1'b1; ia[1] = 32'd4;
    repeat (9) @(posedge clk);
    #1;
    iv[1] = 1'b0; ia[1] = 32'd0;
    repeat (6) @(posedge clk);
    chk("lat3_accepts", 32'(acc1.size()), 32'd3);
    chk("lat3_accept_gap", (acc1.size() >= 2) ? 32'(acc1[1] - acc1[0]) : 32'hFFFFFFFF, 32'd4);
    chk("lat3_rsp_delay", (rsp1.size() >= 1 && acc1.size() >= 1) ? 32'(rsp1[0] - acc1[0]) : 32'hFFFFFFFF, 32'd3);
    chk("lat3_rsps", 32'(rsp1.size()), 32'd3);

    // Reset while a load is in WAIT. No response may follow, and the next fetch is served normally.
    #1;
    rsp1.delete();
    dv[1] = 1'b1; da[1] = 32'd0; dbe[1] = 4'hF; dwe[1] = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (o_dready[1]) got = 1'b1;
    end
    chk("rstwait_accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    dv[1] = 1'b0; dbe[1] = 4'd0;
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_mem_en", 32'(o_men[1]), 32'd0);
    chk("rstwait_d_rsp", 32'(o_drv[1]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    iv[1] = 1'b1; ia[1] = 32'd4;
    @(negedge clk);
    chk("post_rst_first_accept", 32'(o_iready[1]), 32'd1);
    @(posedge clk); #1;
    iv[1] = 1'b0; ia[1] = 32'd0;
    rd = 32'd0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (o_irv[1]) begin
        got = 1'b1;
        rd = o_ird[1];
      end
    end
    chk("post_rst_fetch_seen", 32'(got), 32'd1);
    chk("post_rst_fetch_data", rd, 32'h00100113);
    chk("post_rst_rsp_count", 32'(rsp1.size()), 32'd1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
